// File: rtl/od_port_bank.sv
// od_port_bank: bank of open-drain pads with synchronised readback, edge
// strobes and a sticky bus-conflict flag per channel.
// Optional feature macro: OD_PORT_BANK_FILTER_EN builds the stable-count
// glitch filter. Without it, the filtered level is a one-cycle copy of the
// synchroniser output and FILT_LEN is ignored.
module od_port_bank #(
  parameter int CHANNELS = 2,
  parameter int FILT_LEN = 4,
  parameter int SETTLE   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  inout  wire  [CHANNELS-1:0] io_pins,
  input  logic [CHANNELS-1:0] i_write,
  output logic [CHANNELS-1:0] o_read,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic [CHANNELS-1:0] o_conflict,
  input  logic [CHANNELS-1:0] i_conflict_clr
);

  localparam int            SW     = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SC_MAX = SW'(SETTLE);

  logic [CHANNELS-1:0] s1_q, s2_q;
  logic [CHANNELS-1:0] f_q, f_d;
  logic [CHANNELS-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [CHANNELS-1:0] conf_q, conf_d;
  logic [SW-1:0]       sc_q [CHANNELS];
  logic [SW-1:0]       sc_d [CHANNELS];

  // The block only ever pulls low; a released pad (or any pad in reset)
  // floats and is pulled high by the bus.
  for (genvar n = 0; n < CHANNELS; n++) begin : g_pad
    assign io_pins[n] = (i_write[n] || i_rst) ? 1'bz : 1'b0;
  end

  // Two-flop synchroniser, idling high like the bus
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= io_pins;
      s2_q <= s1_q;
    end
  end

`ifdef OD_PORT_BANK_FILTER_EN
  localparam int            CW       = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [CW-1:0] cnt_q [CHANNELS];
  logic [CW-1:0] cnt_d [CHANNELS];

  // Accept a new level only after it has differed from f for FILT_LEN
  // consecutive cycles; any return to f restarts the count.
  always_comb begin
    f_d = f_q;
    for (int n = 0; n < CHANNELS; n++) begin
      cnt_d[n] = '0;
      if (s2_q[n] == f_q[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] == CNT_LAST) begin
        f_d[n]   = s2_q[n];
        cnt_d[n] = '0;
      end else begin
        cnt_d[n] = cnt_q[n] + CW'(1);
      end
    end
  end

  // Filter stability counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int n = 0; n < CHANNELS; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) cnt_q[n] <= cnt_d[n];
    end
  end
`else
  // Unfiltered: f is simply one more register stage behind s2
  always_comb begin
    f_d = s2_q;
  end
`endif

  // Edge strobes, settle counters and sticky conflict flags
  always_comb begin
    rise_d = f_d & ~f_q;
    fall_d = ~f_d & f_q;
    conf_d = conf_q;
    for (int n = 0; n < CHANNELS; n++) begin
      sc_d[n] = '0;
      if (i_write[n]) begin
        sc_d[n] = (sc_q[n] == SC_MAX) ? sc_q[n] : sc_q[n] + SW'(1);
      end
      // Setting takes priority over clearing; re-driving low does not clear.
      if ((sc_q[n] == SC_MAX) && !f_q[n]) begin
        conf_d[n] = 1'b1;
      end else if (i_conflict_clr[n]) begin
        conf_d[n] = 1'b0;
      end
    end
  end

  // Filtered level, strobes, conflict state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      f_q    <= '1;
      rise_q <= '0;
      fall_q <= '0;
      conf_q <= '0;
      for (int n = 0; n < CHANNELS; n++) sc_q[n] <= '0;
    end else begin
      f_q    <= f_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      conf_q <= conf_d;
      for (int n = 0; n < CHANNELS; n++) sc_q[n] <= sc_d[n];
    end
  end

  assign o_read     = f_q;
  assign o_rise     = rise_q;
  assign o_fall     = fall_q;
  assign o_conflict = conf_q;

endmodule
